// File: rtl/adc_serial_reader.sv
// Serial-ADC readout controller: issues soc on each tick, deserializes an MSB-first
// SI_en-framed bit stream into a parallel word and flags timeout/framing/overrun errors.
module adc_serial_reader #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             SI,
  input  logic             SI_en,
  output logic             soc,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_frame,
  output logic             overrun
);

  // state | meaning
  // IDLE  | waiting for tick; SI_en ignored
  // SOC   | soc pulse out, counters cleared
  // WAIT  | waiting up to TIMEOUT cycles for the first framed bit
  // SHIFT | collecting the remaining bits while SI_en stays high
  typedef enum logic [1:0] {S_IDLE, S_SOC, S_WAIT, S_SHIFT} state_t;

  localparam int BW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, shifted, first;
  logic [BW-1:0]    bit_q, bit_d;
  logic [7:0]       wait_q, wait_d;
  logic [WIDTH-1:0] data_d;
  logic             dv_d, to_d, fe_d;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    wait_d     = wait_q;
    data_d     = data;
    dv_d       = 1'b0;
    to_d       = 1'b0;
    fe_d       = 1'b0;
    shifted    = sr_q << 1;
    shifted[0] = SI;
    first      = '0;
    first[0]   = SI;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_SOC;
      end
      S_SOC: begin
        wait_d  = '0;
        bit_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (SI_en) begin
          sr_d  = first;
          bit_d = BW'(1);
          // a one-bit word is complete on its first capture
          if (WIDTH == 1) begin
            data_d  = first;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SHIFT;
          end
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (SI_en) begin
          sr_d  = shifted;
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(WIDTH - 1)) begin
            data_d  = shifted;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          fe_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_q       <= '0;
      wait_q      <= '0;
      data        <= '0;
      soc         <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      err_frame   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_q       <= bit_d;
      wait_q      <= wait_d;
      data        <= data_d;
      soc         <= (state_d == S_SOC);
      data_valid  <= dv_d;
      busy        <= (state_d != S_IDLE);
      err_timeout <= to_d;
      err_frame   <= fe_d;
      overrun     <= tick && (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: good frame, timeout, framing error, overrun,
// async reset mid-shift and back-to-back conversions with hand-computed expectations.
module tb_adc_serial_reader;
  localparam int WIDTH   = 12;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             si = 1'b0;
  logic             si_en = 1'b0;
  logic             soc, data_valid, busy, err_timeout, err_frame, overrun;
  logic [WIDTH-1:0] data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_dv = 0, n_to = 0, n_fe = 0, n_ov = 0, n_soc = 0, n_busy = 0, n_excl = 0;
  int b_dv, b_to, b_fe, b_ov, b_soc, b_busy;
  int c1, c2;

  always #5 clk = ~clk;

  adc_serial_reader #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .SI(si), .SI_en(si_en),
    .soc(soc), .data(data), .data_valid(data_valid), .busy(busy),
    .err_timeout(err_timeout), .err_frame(err_frame), .overrun(overrun)
  );

  // mid-cycle pulse accounting
  always @(negedge clk) begin
    if (!rst) begin
      n_dv   += int'(data_valid);
      n_to   += int'(err_timeout);
      n_fe   += int'(err_frame);
      n_ov   += int'(overrun);
      n_soc  += int'(soc);
      n_busy += int'(busy);
      if (int'(data_valid) + int'(err_timeout) + int'(err_frame) > 1) n_excl += 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic snap();
    b_dv = n_dv; b_to = n_to; b_fe = n_fe; b_ov = n_ov; b_soc = n_soc; b_busy = n_busy;
  endtask

  task automatic do_tick(input string tag);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq({tag, "_soc"}, 32'(soc), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // gap = WAIT cycles with SI_en low before the first bit; tick_at = bit index carrying a tick
  task automatic frame(input logic [WIDTH-1:0] word, input int nbits, input int gap, input int tick_at);
    repeat (gap + 1) step();
    for (int i = 0; i < nbits; i++) begin
      si_en = 1'b1;
      si    = word[WIDTH-1-i];
      tick  = (i == tick_at);
      step();
    end
    tick  = 1'b0;
    si_en = 1'b0;
    si    = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check_eq("rst_soc", 32'(soc), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_dv", 32'(data_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_errs", {29'd0, err_timeout, err_frame, overrun}, 32'd0);
    rst = 1'b0;
    step();

    // good frame, SI_en after three quiet WAIT cycles, one stray bit after the last
    snap();
    do_tick("good");
    frame(12'hA5C, 12, 3, -1);
    check_eq("good_dv", 32'(data_valid), 32'd1);
    check_eq("good_data", 32'(data), 32'hA5C);
    check_eq("good_busy_end", 32'(busy), 32'd0);
    si_en = 1'b1; si = 1'b1;
    step();
    si_en = 1'b0; si = 1'b0;
    check_eq("extra_bit_busy", 32'(busy), 32'd0);
    step(); step();
    check_eq("good_n_dv", 32'(n_dv - b_dv), 32'd1);
    check_eq("good_n_busy", 32'(n_busy - b_busy), 32'd16);
    check_eq("good_n_err", 32'(n_to - b_to + n_fe - b_fe), 32'd0);
    check_eq("good_n_soc", 32'(n_soc - b_soc), 32'd1);

    // timeout
    snap();
    do_tick("to");
    repeat (TIMEOUT) step();
    check_eq("to_early", 32'(err_timeout), 32'd0);
    step();
    check_eq("to_pulse", 32'(err_timeout), 32'd1);
    check_eq("to_busy", 32'(busy), 32'd0);
    check_eq("to_data", 32'(data), 32'hA5C);
    step(); step();
    check_eq("to_n_to", 32'(n_to - b_to), 32'd1);

    // framing error after 7 of 12 bits
    snap();
    do_tick("fe");
    frame(12'h5A3, 7, 0, -1);
    check_eq("fe_busy_mid", 32'(busy), 32'd1);
    step();
    check_eq("fe_pulse", 32'(err_frame), 32'd1);
    check_eq("fe_busy", 32'(busy), 32'd0);
    check_eq("fe_data", 32'(data), 32'hA5C);
    step(); step();
    check_eq("fe_n_fe", 32'(n_fe - b_fe), 32'd1);
    check_eq("fe_n_dv", 32'(n_dv - b_dv), 32'd0);

    // overrun: second tick during SHIFT
    snap();
    do_tick("ov");
    frame(12'h3C9, 12, 0, 5);
    check_eq("ov_dv", 32'(data_valid), 32'd1);
    check_eq("ov_data", 32'(data), 32'h3C9);
    step(); step(); step();
    check_eq("ov_n_ov", 32'(n_ov - b_ov), 32'd1);
    check_eq("ov_n_soc", 32'(n_soc - b_soc), 32'd1);

    // asynchronous reset after 5 bits
    snap();
    do_tick("rs");
    frame(12'hF0F, 5, 0, -1);
    rst = 1'b1;
    #1;
    check_eq("rs_busy", 32'(busy), 32'd0);
    check_eq("rs_data", 32'(data), 32'd0);
    check_eq("rs_outs", {27'd0, soc, data_valid, err_timeout, err_frame, overrun}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    do_tick("rs2");
    frame(12'h001, 12, 0, -1);
    check_eq("rs2_dv", 32'(data_valid), 32'd1);
    check_eq("rs2_data", 32'(data), 32'h001);
    step(); step();
    check_eq("rs_n_fe", 32'(n_fe - b_fe), 32'd0);
    check_eq("rs_n_dv", 32'(n_dv - b_dv), 32'd1);

    // back-to-back: tick in the data_valid cycle
    snap();
    do_tick("bb1");
    frame(12'hFFF, 12, 1, -1);
    check_eq("bb1_dv", 32'(data_valid), 32'd1);
    check_eq("bb1_data", 32'(data), 32'hFFF);
    c1 = cyc;
    do_tick("bb2");
    frame(12'h000, 12, 1, -1);
    check_eq("bb2_dv", 32'(data_valid), 32'd1);
    check_eq("bb2_data", 32'(data), 32'h000);
    c2 = cyc;
    check_eq("bb_gap", 32'(c2 - c1), 32'd15);
    step(); step();
    check_eq("bb_n_dv", 32'(n_dv - b_dv), 32'd2);
    check_eq("bb_n_ov", 32'(n_ov - b_ov), 32'd0);
    check_eq("bb_n_soc", 32'(n_soc - b_soc), 32'd2);

    check_eq("pulse_excl", 32'(n_excl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
